// File: rtl/interrupt_ctrl_mod_if.sv
// Bundles the interrupt controller's register port, CPU event pulses and
// dispatch handshake. The master side is the CPU/IO decode, the slave side
// is the controller.
interface interrupt_ctrl_mod_if #(
  parameter int NUM_IRQ = 5
);
  logic [NUM_IRQ-1:0] irq_src;
  logic               reg_wr_en;
  logic               reg_sel;
  logic [7:0]         reg_wdata;
  logic [7:0]         reg_rdata;
  logic               inst_boundary;
  logic               ei_exec;
  logic               di_exec;
  logic               reti_exec;
  logic               halt_exec;
  logic               dispatch_req;
  logic               dispatch_ack;
  logic [7:0]         dispatch_vector;
  logic               dispatch_busy;
  logic               ime;
  logic               halted;

  modport master (
    output irq_src, reg_wr_en, reg_sel, reg_wdata, inst_boundary,
           ei_exec, di_exec, reti_exec, halt_exec, dispatch_ack,
    input  reg_rdata, dispatch_req, dispatch_vector, dispatch_busy, ime, halted
  );

  modport slave (
    input  irq_src, reg_wr_en, reg_sel, reg_wdata, inst_boundary,
           ei_exec, di_exec, reti_exec, halt_exec, dispatch_ack,
    output reg_rdata, dispatch_req, dispatch_vector, dispatch_busy, ime, halted
  );
endinterface

// File: rtl/interrupt_ctrl_mod.sv
// Interrupt controller: IF/IE registers, IME with delayed EI enable,
// lowest-index-first priority, dispatch request/ack sequencing and HALT
// tracking. Bit 0 of IF/IE is the highest priority source.
module interrupt_ctrl_mod #(
  parameter int         NUM_IRQ         = 5,
  parameter logic [7:0] VEC_BASE        = 8'h40,
  parameter logic [7:0] VEC_STRIDE      = 8'h08,
  parameter int         DISPATCH_CYCLES = 5
) (
  input logic                 clock,
  input logic                 reset,
  interrupt_ctrl_mod_if.slave bus
);
  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int CNT_W = $clog2(DISPATCH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DISPATCH_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_DISPATCH = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [NUM_IRQ-1:0] if_reg, if_next;
  logic [7:0]         ie_reg, ie_next;
  logic               ime_reg, ime_next;
  logic [1:0]         ei_cnt_reg, ei_cnt_next;
  logic [CNT_W-1:0]   busy_cnt_reg, busy_cnt_next;
  logic [7:0]         vector_reg, vector_next;
  logic               halted_reg, halted_next;

  logic [NUM_IRQ-1:0] pending;
  logic               pending_any;
  logic [NUM_IRQ-1:0] idx_mask;
  logic [IDX_W-1:0]   idx;
  logic [7:0]         vector_calc;
  logic               ack_take;
  logic               ei_fire;
  logic               ime_eff;
  logic [7:0]         if_rdata;

  assign pending     = ie_reg[NUM_IRQ-1:0] & if_reg;
  assign pending_any = |pending;
  // Isolate the lowest set bit: that is the winning source.
  assign idx_mask    = pending & (~pending + NUM_IRQ'(1));
  assign vector_calc = VEC_BASE + VEC_STRIDE * 8'(idx);
  assign ack_take    = (state_reg == ST_REQ) && bus.dispatch_ack && pending_any;
  // EI countdown expiring at this boundary enables interrupts for this very boundary.
  assign ei_fire     = !bus.di_exec && !bus.ei_exec && bus.inst_boundary && (ei_cnt_reg == 2'd1);
  assign ime_eff     = !bus.di_exec && (ime_reg || ei_fire);

  // IF readback: implemented bits from the register, unused upper bits read as 1.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_if_rd
      if (gi < NUM_IRQ) begin : g_used
        assign if_rdata[gi] = if_reg[gi];
      end else begin : g_unused
        assign if_rdata[gi] = 1'b1;
      end
    end
  endgenerate

  // Priority encoder: index of the lowest pending source.
  always_comb begin
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) idx = IDX_W'(i);
    end
  end

  // State and register file, cleared asynchronously.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      if_reg       <= '0;
      ie_reg       <= '0;
      ime_reg      <= 1'b0;
      ei_cnt_reg   <= 2'd0;
      busy_cnt_reg <= '0;
      vector_reg   <= 8'h00;
      halted_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      if_reg       <= if_next;
      ie_reg       <= ie_next;
      ime_reg      <= ime_next;
      ei_cnt_reg   <= ei_cnt_next;
      busy_cnt_reg <= busy_cnt_next;
      vector_reg   <= vector_next;
      halted_reg   <= halted_next;
    end
  end

  // Next-state logic for the dispatch sequencer.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.inst_boundary && ime_eff && pending_any && !halted_reg)
          state_next = ST_REQ;
      end
      ST_REQ: begin
        if (!pending_any)
          state_next = ST_IDLE;
        else if (bus.dispatch_ack)
          state_next = ST_DISPATCH;
      end
      ST_DISPATCH: begin
        if (busy_cnt_reg <= CNT_W'(1))
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Register, IME, EI countdown, busy counter, vector and HALT updates.
  always_comb begin
    // IF: register write, then ack clear, then new requests (a new request wins).
    if_next = if_reg;
    if (bus.reg_wr_en && !bus.reg_sel) if_next = bus.reg_wdata[NUM_IRQ-1:0];
    if (ack_take) if_next = if_next & ~idx_mask;
    if_next = if_next | bus.irq_src;

    ie_next = ie_reg;
    if (bus.reg_wr_en && bus.reg_sel) ie_next = bus.reg_wdata;

    ei_cnt_next = ei_cnt_reg;
    if (bus.di_exec)
      ei_cnt_next = 2'd0;
    else if (bus.ei_exec)
      ei_cnt_next = 2'd2;
    else if (bus.inst_boundary && (ei_cnt_reg != 2'd0))
      ei_cnt_next = ei_cnt_reg - 2'd1;

    if (bus.di_exec || ack_take)
      ime_next = 1'b0;
    else
      ime_next = ime_reg || ei_fire || bus.reti_exec;

    busy_cnt_next = busy_cnt_reg;
    if (ack_take)
      busy_cnt_next = CNT_LOAD;
    else if ((state_reg == ST_DISPATCH) && (busy_cnt_reg != '0))
      busy_cnt_next = busy_cnt_reg - CNT_W'(1);

    vector_next = vector_reg;
    if (ack_take) vector_next = vector_calc;

    halted_next = halted_reg;
    if (pending_any)
      halted_next = 1'b0;
    else if (bus.halt_exec)
      halted_next = 1'b1;
  end

  // Output decode from state and registers.
  always_comb begin
    bus.dispatch_req    = (state_reg == ST_REQ);
    bus.dispatch_busy   = (state_reg == ST_DISPATCH);
    bus.dispatch_vector = vector_reg;
    bus.ime             = ime_reg;
    bus.halted          = halted_reg;
    bus.reg_rdata       = bus.reg_sel ? ie_reg : if_rdata;
  end
endmodule
